// File: rtl/reg_rename_ctrl.sv
// Rename-stage controller: speculative/committed arch->phys maps, free-list pop/push sequencing.
// Latency: rename lookup and allocation are combinational; map updates land at the next clock.
// Backpressure: rn_ready drops on flush, in RECOVER, or when the free list is empty and a dest is needed.
// Optional stall counter output is enabled with `define REG_RENAME_STALL_CNT_EN.
module reg_rename_ctrl #(
  parameter int REG_FILE_ADDR_WIDTH = 7,
  parameter int ARCH_REGS           = 32
) (
  input  logic                           clock,
  input  logic                           reset,
`ifdef REG_RENAME_STALL_CNT_EN
  output logic [15:0]                    stall_count,
`endif
  input  logic                           rn_valid,
  output logic                           rn_ready,
  input  logic                           rn_rd_wr,
  input  logic [4:0]                     rn_rd,
  input  logic [4:0]                     rn_rs1,
  input  logic [4:0]                     rn_rs2,
  output logic [REG_FILE_ADDR_WIDTH-1:0] rn_prs1,
  output logic [REG_FILE_ADDR_WIDTH-1:0] rn_prs2,
  output logic [REG_FILE_ADDR_WIDTH-1:0] rn_prd,
  output logic [REG_FILE_ADDR_WIDTH-1:0] rn_old_prd,
  output logic                           fl_take,
  input  logic [REG_FILE_ADDR_WIDTH-1:0] fl_free_reg_num,
  input  logic                           fl_empty,
  input  logic                           fl_full,
  output logic                           fl_free,
  output logic [REG_FILE_ADDR_WIDTH-1:0] fl_freed_reg_num,
  input  logic                           cm_valid,
  input  logic                           cm_rd_wr,
  input  logic [4:0]                     cm_rd,
  input  logic [REG_FILE_ADDR_WIDTH-1:0] cm_prd,
  input  logic [REG_FILE_ADDR_WIDTH-1:0] cm_old_prd,
  input  logic                           flush,
  input  logic                           sq_valid,
  input  logic [REG_FILE_ADDR_WIDTH-1:0] sq_prd,
  output logic                           sq_ready,
  input  logic                           sq_done,
  output logic                           recovering,
  output logic                           free_overflow
);

  localparam int PW = REG_FILE_ADDR_WIDTH;

  typedef enum logic {
    RUN     = 1'b0,
    RECOVER = 1'b1
  } state_t;

  state_t        state;
  logic [PW-1:0] spec_map   [ARCH_REGS];
  logic [PW-1:0] commit_map [ARCH_REGS];

  logic alloc;
  logic commit_free;
  logic squash_free;
  logic rn_fire;

  // Rename lookup, ready/take handshake and free-port arbitration (commit beats squash).
  always_comb begin
    alloc       = rn_rd_wr && (rn_rd != 5'd0);
    commit_free = reset && cm_valid && cm_rd_wr && (cm_rd != 5'd0);
    rn_ready    = reset && (state == RUN) && !flush && (!alloc || !fl_empty);
    rn_fire     = rn_valid && rn_ready;
    fl_take     = rn_fire && alloc;
    rn_prs1     = (rn_rs1 == 5'd0) ? '0 : spec_map[rn_rs1];
    rn_prs2     = (rn_rs2 == 5'd0) ? '0 : spec_map[rn_rs2];
    rn_old_prd  = spec_map[rn_rd];
    rn_prd      = alloc ? fl_free_reg_num : '0;
    sq_ready    = reset && (state == RECOVER) && !commit_free;
    squash_free = sq_valid && sq_ready;
    fl_free     = commit_free || squash_free;
    recovering  = reset && (state == RECOVER);
    if (commit_free) begin
      fl_freed_reg_num = cm_old_prd;
    end else if (squash_free) begin
      fl_freed_reg_num = sq_prd;
    end else begin
      fl_freed_reg_num = '0;
    end
  end

  // Map maintenance: commit updates the recovery map; flush restores the speculative map from it,
  // folding in a same-cycle commit so the restored view is never one commit stale.
  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int i = 0; i < ARCH_REGS; i++) begin
        spec_map[i]   <= PW'(i);
        commit_map[i] <= PW'(i);
      end
    end else begin
      for (int i = 0; i < ARCH_REGS; i++) begin
        if (commit_free && (cm_rd == 5'(i))) begin
          commit_map[i] <= cm_prd;
        end
      end
      if (flush) begin
        for (int i = 0; i < ARCH_REGS; i++) begin
          spec_map[i] <= (commit_free && (cm_rd == 5'(i))) ? cm_prd : commit_map[i];
        end
      end else if (fl_take) begin
        spec_map[rn_rd] <= fl_free_reg_num;
      end
    end
  end

  // RUN/RECOVER sequencing; a repeated flush keeps us recovering even if sq_done arrives with it.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state <= RUN;
    end else begin
      case (state)
        RUN:     if (flush) state <= RECOVER;
        RECOVER: if (!flush && sq_done) state <= RUN;
        default: state <= RUN;
      endcase
    end
  end

  // Sticky flag: a push was driven while the free list reported full.
  always_ff @(posedge clock) begin
    if (!reset) begin
      free_overflow <= 1'b0;
    end else if (fl_free && fl_full) begin
      free_overflow <= 1'b1;
    end
  end

`ifdef REG_RENAME_STALL_CNT_EN
  // Saturating count of cycles where decode offered an instruction and was held off.
  always_ff @(posedge clock) begin
    if (!reset) begin
      stall_count <= 16'd0;
    end else if (rn_valid && !rn_ready && (stall_count != 16'hFFFF)) begin
      stall_count <= stall_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_reg_rename_ctrl.sv
// Bench for reg_rename_ctrl: directed scenarios followed by random traffic,
// all compared against an array-based reference of the rename/commit maps.
// Inputs change 1ns after the rising edge; outputs are compared mid-cycle.
module tb_reg_rename_ctrl;

  localparam int PW = 7;

  logic          clock;
  logic          reset;
  logic          rn_valid, rn_ready, rn_rd_wr;
  logic [4:0]    rn_rd, rn_rs1, rn_rs2;
  logic [PW-1:0] rn_prs1, rn_prs2, rn_prd, rn_old_prd;
  logic          fl_take, fl_empty, fl_full, fl_free;
  logic [PW-1:0] fl_free_reg_num, fl_freed_reg_num;
  logic          cm_valid, cm_rd_wr;
  logic [4:0]    cm_rd;
  logic [PW-1:0] cm_prd, cm_old_prd;
  logic          flush, sq_valid, sq_ready, sq_done;
  logic [PW-1:0] sq_prd;
  logic          recovering, free_overflow;
`ifdef REG_RENAME_STALL_CNT_EN
  logic [15:0]   stall_count;
  int            m_stall;
`endif

  int m_spec   [32];
  int m_commit [32];
  bit m_rec;
  bit m_ovf;
  int total  = 0;
  int passed = 0;
  int fails  = 0;

  reg_rename_ctrl #(.REG_FILE_ADDR_WIDTH(PW), .ARCH_REGS(32)) dut (
    .clock(clock), .reset(reset),
`ifdef REG_RENAME_STALL_CNT_EN
    .stall_count(stall_count),
`endif
    .rn_valid(rn_valid), .rn_ready(rn_ready), .rn_rd_wr(rn_rd_wr),
    .rn_rd(rn_rd), .rn_rs1(rn_rs1), .rn_rs2(rn_rs2),
    .rn_prs1(rn_prs1), .rn_prs2(rn_prs2), .rn_prd(rn_prd), .rn_old_prd(rn_old_prd),
    .fl_take(fl_take), .fl_free_reg_num(fl_free_reg_num), .fl_empty(fl_empty),
    .fl_full(fl_full), .fl_free(fl_free), .fl_freed_reg_num(fl_freed_reg_num),
    .cm_valid(cm_valid), .cm_rd_wr(cm_rd_wr), .cm_rd(cm_rd), .cm_prd(cm_prd),
    .cm_old_prd(cm_old_prd), .flush(flush), .sq_valid(sq_valid), .sq_prd(sq_prd),
    .sq_ready(sq_ready), .sq_done(sq_done), .recovering(recovering),
    .free_overflow(free_overflow)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic idle();
    rn_valid = 0; rn_rd_wr = 0; rn_rd = 0; rn_rs1 = 0; rn_rs2 = 0;
    fl_free_reg_num = 0; fl_empty = 0; fl_full = 0;
    cm_valid = 0; cm_rd_wr = 0; cm_rd = 0; cm_prd = 0; cm_old_prd = 0;
    flush = 0; sq_valid = 0; sq_prd = 0; sq_done = 0;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      m_spec[i]   = i;
      m_commit[i] = i;
    end
    m_rec = 0;
    m_ovf = 0;
`ifdef REG_RENAME_STALL_CNT_EN
    m_stall = 0;
`endif
  endtask

  // Compare every output against the reference for the current inputs, then advance one clock.
  task automatic step();
    bit alloc, cfree, e_ready, fire, sqr, sqf, e_free;
    int e_fnum;
    #1;
    alloc   = rn_rd_wr && (rn_rd != 0);
    cfree   = cm_valid && cm_rd_wr && (cm_rd != 0);
    e_ready = !m_rec && !flush && (!alloc || !fl_empty);
    fire    = rn_valid && e_ready;
    sqr     = m_rec && !cfree;
    sqf     = sq_valid && sqr;
    e_free  = cfree || sqf;
    e_fnum  = cfree ? int'(cm_old_prd) : int'(sq_prd);
    check("rn_ready", rn_ready, e_ready);
    check("rn_prs1", rn_prs1, (rn_rs1 == 0) ? 0 : m_spec[rn_rs1]);
    check("rn_prs2", rn_prs2, (rn_rs2 == 0) ? 0 : m_spec[rn_rs2]);
    check("rn_old_prd", rn_old_prd, m_spec[rn_rd]);
    check("rn_prd", rn_prd, alloc ? int'(fl_free_reg_num) : 0);
    check("fl_take", fl_take, fire && alloc);
    check("sq_ready", sq_ready, sqr);
    check("fl_free", fl_free, e_free);
    if (e_free) check("fl_freed_reg_num", fl_freed_reg_num, e_fnum);
    check("recovering", recovering, m_rec);
    check("free_overflow", free_overflow, m_ovf);
`ifdef REG_RENAME_STALL_CNT_EN
    check("stall_count", stall_count, m_stall);
    if (rn_valid && !e_ready && m_stall < 65535) m_stall++;
`endif
    if (cfree) m_commit[cm_rd] = cm_prd;
    if (flush) begin
      for (int i = 0; i < 32; i++) m_spec[i] = m_commit[i];
    end else if (fire && alloc) begin
      m_spec[rn_rd] = fl_free_reg_num;
    end
    if (e_free && fl_full) m_ovf = 1;
    if (flush) m_rec = 1;
    else if (m_rec && sq_done) m_rec = 0;
    @(posedge clock);
    #1;
  endtask

  initial begin
    idle();
    reset = 0;
    // Reset held low with every request asserted: all handshake outputs stay quiet.
    rn_valid = 1; rn_rd_wr = 1; rn_rd = 9; cm_valid = 1; cm_rd_wr = 1; cm_rd = 2;
    sq_valid = 1; flush = 1;
    repeat (2) @(posedge clock);
    #2;
    check("rst_rn_ready", rn_ready, 0);
    check("rst_fl_take", fl_take, 0);
    check("rst_fl_free", fl_free, 0);
    check("rst_sq_ready", sq_ready, 0);
    check("rst_recovering", recovering, 0);
    check("rst_overflow", free_overflow, 0);
    idle();
    @(posedge clock);
    #1;
    reset = 1;
    model_reset();
    rn_rs1 = 17; rn_rs2 = 31;
    #1;
    check("rst_map_rs1", rn_prs1, 17);
    check("rst_map_rs2", rn_prs2, 31);
    step();

    // Basic rename with allocation, then the new mapping is visible next cycle.
    idle(); rn_valid = 1; rn_rd_wr = 1; rn_rd = 5; rn_rs1 = 5; fl_free_reg_num = 32;
    #1;
    check("t1_old_prd", rn_old_prd, 5);
    check("t1_prd", rn_prd, 32);
    check("t1_take", fl_take, 1);
    step();
    idle(); rn_rs1 = 5;
    #1;
    check("t1_prs1", rn_prs1, 32);
    step();

    // x0 destination never allocates, so an empty free list does not stall it.
    idle(); rn_valid = 1; rn_rd_wr = 1; rn_rd = 0; fl_empty = 1; fl_free_reg_num = 44;
    #1;
    check("t2_prd", rn_prd, 0);
    check("t2_take", fl_take, 0);
    check("t2_ready", rn_ready, 1);
    step();

    // Real destination with empty free list stalls until the list refills.
    idle(); rn_valid = 1; rn_rd_wr = 1; rn_rd = 7; fl_empty = 1; fl_free_reg_num = 35;
    #1;
    check("t3_ready", rn_ready, 0);
    check("t3_take", fl_take, 0);
    step();
    fl_empty = 0;
    #1;
    check("t3_take_refill", fl_take, 1);
    step();

    // In RECOVER, a commit free blocks the squash free for that cycle.
    idle(); flush = 1;
    step();
    idle(); cm_valid = 1; cm_rd_wr = 1; cm_rd = 3; cm_prd = 40; cm_old_prd = 3;
    sq_valid = 1; sq_prd = 50;
    #1;
    check("t4_freed", fl_freed_reg_num, 3);
    check("t4_sq_ready", sq_ready, 0);
    step();
    idle(); sq_valid = 1; sq_prd = 50;
    #1;
    check("t4_sq_free", fl_free, 1);
    check("t4_sq_freed", fl_freed_reg_num, 50);
    step();
    idle(); sq_done = 1;
    step();

    // Uncommitted rename is discarded by flush.
    idle(); rn_valid = 1; rn_rd_wr = 1; rn_rd = 4; fl_free_reg_num = 33;
    step();
    idle(); flush = 1; rn_valid = 1; rn_rd_wr = 1; rn_rd = 9;
    #1;
    check("t5_flush_ready", rn_ready, 0);
    step();
    idle(); rn_valid = 1;
    #1;
    check("t5_recovering", recovering, 1);
    check("t5_rec_ready", rn_ready, 0);
    step();
    idle(); sq_done = 1;
    step();
    idle(); rn_valid = 1; rn_rs1 = 4;
    #1;
    check("t5_prs1", rn_prs1, 4);
    step();

    // Commit into a full free list raises the sticky overflow flag.
    idle(); cm_valid = 1; cm_rd_wr = 1; cm_rd = 6; cm_prd = 60; cm_old_prd = 6; fl_full = 1;
    #1;
    check("t6_free", fl_free, 1);
    step();
    idle();
    repeat (3) step();
    check("t6_sticky", free_overflow, 1);

    // Reset while recovering returns to RUN with identity maps.
    idle(); flush = 1;
    step();
    idle(); reset = 0;
    @(posedge clock);
    #1;
    reset = 1;
    model_reset();
    rn_rs1 = 6; rn_rs2 = 5;
    #1;
    check("t7_recovering", recovering, 0);
    check("t7_prs1", rn_prs1, 6);
    check("t7_prs2", rn_prs2, 5);
    check("t7_overflow", free_overflow, 0);
    step();

    // Random traffic against the reference maps.
    for (int n = 0; n < 600; n++) begin
      rn_valid        = 1'($urandom_range(0, 1));
      rn_rd_wr        = ($urandom_range(0, 3) != 0);
      rn_rd           = 5'($urandom_range(0, 31));
      rn_rs1          = 5'($urandom_range(0, 31));
      rn_rs2          = 5'($urandom_range(0, 31));
      fl_free_reg_num = PW'($urandom_range(32, 127));
      fl_empty        = ($urandom_range(0, 3) == 0);
      fl_full         = ($urandom_range(0, 15) == 0);
      cm_valid        = 1'($urandom_range(0, 1));
      cm_rd_wr        = ($urandom_range(0, 3) != 0);
      cm_rd           = 5'($urandom_range(0, 31));
      cm_prd          = PW'($urandom_range(0, 127));
      cm_old_prd      = PW'($urandom_range(0, 127));
      flush           = ($urandom_range(0, 19) == 0);
      sq_valid        = 1'($urandom_range(0, 1));
      sq_prd          = PW'($urandom_range(0, 127));
      sq_done         = ($urandom_range(0, 7) == 0);
      step();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/reg_rename_ctrl.md
Name: reg_rename_ctrl

Overview:
Rename-stage controller that sequences the physical register free list. Keeps a speculative map (arch->phys) for renaming and a committed map for recovery. Pops free physical registers for renamed destinations and arbitrates the free list's single free port between commit frees and squash frees. Sits between decode, the free list and the ROB.

Parameters:
REG_FILE_ADDR_WIDTH, 7, physical register index width (PW)
ARCH_REGS, 32, architectural register count; arch index width fixed at 5

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-low reset
rn_valid  in  1  decode presents an instruction to rename
rn_ready  out  1  controller accepts rename this cycle
rn_rd_wr  in  1  instruction writes rd
rn_rd / rn_rs1 / rn_rs2  in  5 each  architectural indices
rn_prs1 / rn_prs2  out  PW each  physical sources, combinational
rn_prd  out  PW  allocated physical dest (0 if no alloc)
rn_old_prd  out  PW  previous mapping of rn_rd, for the ROB
fl_take  out  1  pop request to free list (take_next_free)
fl_free_reg_num  in  PW  head of free list
fl_empty / fl_full  in  1 each  free list status
fl_free  out  1  push request to free list (reg_freed)
fl_freed_reg_num  out  PW  register being returned
cm_valid  in  1  commit pulse, always accepted
cm_rd_wr / cm_rd / cm_prd / cm_old_prd  in  1/5/PW/PW  committed instruction
flush  in  1  mispredict/exception flush pulse
sq_valid  in  1  ROB returns a squashed prd
sq_prd  in  PW  squashed physical dest
sq_ready  out  1  squash free accepted
sq_done  in  1  ROB finished squash stream
recovering  out  1  high in RECOVER state
free_overflow  out  1  sticky: free attempted while fl_full

Behaviour:
- Reset (reset==0 at posedge): spec_map[i]=commit_map[i]=i for i in 0..31, state=RUN, free_overflow=0. While reset is low, rn_ready, fl_take, fl_free, sq_ready, recovering = 0.
- States: RUN, RECOVER. RUN->RECOVER on flush. RECOVER->RUN on sq_done without flush. Flush in RECOVER re-copies and stays in RECOVER.
- alloc = rn_rd_wr && rn_rd!=0. rn_ready = state==RUN && !flush && (!alloc || !fl_empty). fire = rn_valid && rn_ready.
- Rename is combinational, same cycle: rn_prs1/2 = spec_map[rs] (x0 always maps to 0). rn_old_prd = spec_map[rn_rd]. rn_prd = alloc ? fl_free_reg_num : 0. fl_take = fire && alloc.
- On a fire with alloc, spec_map[rn_rd] <= fl_free_reg_num at the posedge.
- No rename-to-rename bypass is needed: the next instruction reads the updated map on the next cycle.
- Commit (cm_valid && cm_rd_wr && cm_rd!=0): commit_map[cm_rd] <= cm_prd, and cm_old_prd is freed the same cycle (fl_free=1, fl_freed_reg_num=cm_old_prd).
- Free arbitration: commit has fixed priority. sq_ready = state==RECOVER && !commit_free. A squash free happens when sq_valid && sq_ready, pushing sq_prd.
- At most one fl_free per cycle. If fl_full is high when fl_free would assert, the push is still driven and free_overflow is set (sticky until reset).
- Flush cycle: spec_map <= commit_map as it stands after that cycle's commit update, i.e. a same-cycle commit is included. rn_ready=0 in the flush cycle and throughout RECOVER.
- sq_done with sq_valid in the same cycle: the squash free is processed if granted, and the state still returns to RUN. A squash denied that cycle is lost, so the ROB must not assert both unless sq_ready=1.
- Reset mid-RECOVER returns to RUN with identity maps.

Optional Feature:
REG_RENAME_STALL_CNT_EN
- Defined: adds output stall_count[15:0], incremented each cycle rn_valid && !rn_ready. It saturates at 0xFFFF and clears on reset.
- Undefined: the port and counter are absent, with no other change.

Test Plan:
- After reset, rename rd=5, rs1=5, fl_free_reg_num=32 -> rn_old_prd=5, rn_prd=32, fl_take=1; next cycle rs1=5 -> rn_prs1=32.
- rn_rd_wr=1, rd=0 -> rn_prd=0, fl_take=0, rn_ready=1 even with fl_empty=1.
- rd=7 with fl_empty=1 -> rn_ready=0, fl_take=0; deassert fl_empty -> fire in that cycle.
- cm_valid (rd=3, prd=40, old=3) together with sq_valid in RECOVER -> fl_freed_reg_num=3, sq_ready=0; the next cycle frees sq_prd.
- Rename rd=4->33, then flush with no commit -> recovering=1, rn_ready=0; after sq_done, rs1=4 -> rn_prs1=4.
- Commit while fl_full=1 -> free_overflow=1 and stays set until reset.
